// File: rtl/mem_arb_pkg.sv
// Shared types for the imem/dmem memory-port arbiter: request/response
// messages, requester IDs and the grant selection helper.
package mem_arb_pkg;

    typedef enum logic {
        MEM_OP_READ  = 1'b0,
        MEM_OP_WRITE = 1'b1
    } mem_op_t;

    typedef struct packed {
        mem_op_t     op;
        logic [31:0] addr;
        logic [31:0] data;
    } mem_req_t;

    typedef struct packed {
        mem_op_t     op;
        logic [31:0] data;
    } mem_resp_t;

    typedef enum logic {
        REQ_IMEM = 1'b0,
        REQ_DMEM = 1'b1
    } req_id_t;

    localparam int ARB_MODE_RR    = 0;
    localparam int ARB_MODE_FIXED = 1;

    // With a lone candidate it simply wins; only a tie consults the policy.
    function automatic req_id_t pick_winner(
        input logic    imem_cand,
        input logic    dmem_cand,
        input req_id_t last_grant,
        input logic    dmem_priority
    );
        if (imem_cand && dmem_cand) begin
            if (dmem_priority) begin
                return REQ_DMEM;
            end
            return (last_grant == REQ_IMEM) ? REQ_DMEM : REQ_IMEM;
        end
        return dmem_cand ? REQ_DMEM : REQ_IMEM;
    endfunction

endpackage

// File: rtl/mem_arb_route_fifo.sv
// In-order record of which requester issued each outstanding memory request;
// the head tells the arbiter where the next memory response belongs.
module mem_arb_route_fifo
    import mem_arb_pkg::*;
#(
    parameter int p_depth = 4,
    localparam int CNT_W  = $clog2(p_depth + 1),
    localparam int PTR_W  = (p_depth > 1) ? $clog2(p_depth) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             push_id,
    input  logic             pop,
    output logic             head_id,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [p_depth-1:0] slots;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               do_push;
    logic               do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(p_depth - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    // Full/empty come from the registered count, so a same-cycle pop never
    // frees room for a push into a full FIFO.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    assign full    = (count == CNT_W'(p_depth));
    assign empty   = (count == '0);
    assign head_id = slots[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slots  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                slots[wr_ptr] <= push_id;
                wr_ptr        <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction-fetch and data requesters and
// steers the in-order memory responses back to whoever issued each request.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int p_max_in_flight = 4,
    parameter int p_arb_mode      = ARB_MODE_RR,
    localparam int CNT_W          = $clog2(p_max_in_flight + 1)
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             imem_req_val,
    output logic             imem_req_rdy,
    input  mem_req_t         imem_req_msg,
    output logic             imem_resp_val,
    input  logic             imem_resp_rdy,
    output mem_resp_t        imem_resp_msg,

    input  logic             dmem_req_val,
    output logic             dmem_req_rdy,
    input  mem_req_t         dmem_req_msg,
    output logic             dmem_resp_val,
    input  logic             dmem_resp_rdy,
    output mem_resp_t        dmem_resp_msg,

    output logic             mem_req_val,
    input  logic             mem_req_rdy,
    output mem_req_t         mem_req_msg,
    input  logic             mem_resp_val,
    output logic             mem_resp_rdy,
    input  mem_resp_t        mem_resp_msg,

    output logic [CNT_W-1:0] in_flight,
    output logic             resp_err
);

    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_head;
    logic [CNT_W-1:0] fifo_count;

    req_id_t          last_grant;
    req_id_t          winner;
    req_id_t          head_id;
    logic             imem_cand;
    logic             dmem_cand;
    logic             req_fire;
    logic             resp_route;
    logic             resp_fire;

    // Gating on rst keeps every handshake output low while reset is held,
    // even with requesters already asserting valid.
    assign imem_cand = rst & imem_req_val & ~fifo_full;
    assign dmem_cand = rst & dmem_req_val & ~fifo_full;
    assign winner    = pick_winner(imem_cand, dmem_cand, last_grant,
                                   p_arb_mode == ARB_MODE_FIXED);

    assign mem_req_val  = imem_cand | dmem_cand;
    assign mem_req_msg  = (winner == REQ_DMEM) ? dmem_req_msg : imem_req_msg;
    assign imem_req_rdy = imem_cand & (winner == REQ_IMEM) & mem_req_rdy;
    assign dmem_req_rdy = dmem_cand & (winner == REQ_DMEM) & mem_req_rdy;
    assign req_fire     = mem_req_val & mem_req_rdy;

    assign head_id       = req_id_t'(fifo_head);
    assign resp_route    = rst & ~fifo_empty;
    assign imem_resp_val = resp_route & mem_resp_val & (head_id == REQ_IMEM);
    assign dmem_resp_val = resp_route & mem_resp_val & (head_id == REQ_DMEM);
    assign mem_resp_rdy  = resp_route &
                           ((head_id == REQ_IMEM) ? imem_resp_rdy : dmem_resp_rdy);
    assign resp_fire     = mem_resp_val & mem_resp_rdy;
    assign imem_resp_msg = mem_resp_msg;
    assign dmem_resp_msg = mem_resp_msg;
    assign in_flight     = fifo_count;

    mem_arb_route_fifo #(
        .p_depth (p_max_in_flight)
    ) u_route_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (req_fire),
        .push_id (winner == REQ_DMEM),
        .pop     (resp_fire),
        .head_id (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Starting from dmem-last lets imem take the very first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= REQ_DMEM;
        end else if (req_fire) begin
            last_grant <= winner;
        end
    end

    // A response with nothing outstanding means memory and arbiter disagree;
    // the flag stays up until the next reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_err <= 1'b0;
        end else if (mem_resp_val && fifo_empty) begin
            resp_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised and directed bench for mem_arbiter, checked against a queue-based
// model of outstanding requests and the arbitration rules.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int DEPTH = 4;

    logic      clk = 1'b0;
    logic      rst;

    logic      imem_req_val, imem_req_rdy, imem_resp_val, imem_resp_rdy;
    logic      dmem_req_val, dmem_req_rdy, dmem_resp_val, dmem_resp_rdy;
    logic      mem_req_val, mem_req_rdy, mem_resp_val, mem_resp_rdy;
    mem_req_t  imem_req_msg, dmem_req_msg, mem_req_msg;
    mem_resp_t imem_resp_msg, dmem_resp_msg, mem_resp_msg;
    logic [2:0] in_flight;
    logic      resp_err;

    logic      imem_req_rdy_f, dmem_req_rdy_f, imem_resp_val_f, dmem_resp_val_f;
    logic      mem_req_val_f, mem_resp_rdy_f, resp_err_f;
    mem_req_t  mem_req_msg_f;
    mem_resp_t imem_resp_msg_f, dmem_resp_msg_f;
    logic [2:0] in_flight_f;

    int total = 0;
    int bad   = 0;

    // reference model state: outstanding requester IDs in issue order
    int q[$];
    int last_id;
    bit err;
    bit e_req_fire, e_resp_fire, e_spur;
    int e_win;

    always #5 clk = ~clk;

    mem_arbiter #(.p_max_in_flight(DEPTH), .p_arb_mode(0)) u_dut (
        .clk(clk), .rst(rst),
        .imem_req_val(imem_req_val), .imem_req_rdy(imem_req_rdy), .imem_req_msg(imem_req_msg),
        .imem_resp_val(imem_resp_val), .imem_resp_rdy(imem_resp_rdy), .imem_resp_msg(imem_resp_msg),
        .dmem_req_val(dmem_req_val), .dmem_req_rdy(dmem_req_rdy), .dmem_req_msg(dmem_req_msg),
        .dmem_resp_val(dmem_resp_val), .dmem_resp_rdy(dmem_resp_rdy), .dmem_resp_msg(dmem_resp_msg),
        .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_msg(mem_req_msg),
        .mem_resp_val(mem_resp_val), .mem_resp_rdy(mem_resp_rdy), .mem_resp_msg(mem_resp_msg),
        .in_flight(in_flight), .resp_err(resp_err)
    );

    mem_arbiter #(.p_max_in_flight(DEPTH), .p_arb_mode(1)) u_dut_fixed (
        .clk(clk), .rst(rst),
        .imem_req_val(imem_req_val), .imem_req_rdy(imem_req_rdy_f), .imem_req_msg(imem_req_msg),
        .imem_resp_val(imem_resp_val_f), .imem_resp_rdy(imem_resp_rdy), .imem_resp_msg(imem_resp_msg_f),
        .dmem_req_val(dmem_req_val), .dmem_req_rdy(dmem_req_rdy_f), .dmem_req_msg(dmem_req_msg),
        .dmem_resp_val(dmem_resp_val_f), .dmem_resp_rdy(dmem_resp_rdy), .dmem_resp_msg(dmem_resp_msg_f),
        .mem_req_val(mem_req_val_f), .mem_req_rdy(mem_req_rdy), .mem_req_msg(mem_req_msg_f),
        .mem_resp_val(mem_resp_val), .mem_resp_rdy(mem_resp_rdy_f), .mem_resp_msg(mem_resp_msg),
        .in_flight(in_flight_f), .resp_err(resp_err_f)
    );

    function automatic mem_req_t mkReq(input logic [31:0] addr);
        mem_req_t r;
        r.op   = MEM_OP_READ;
        r.addr = addr;
        r.data = 32'h0;
        return r;
    endfunction

    function automatic mem_resp_t mkResp(input logic [31:0] data);
        mem_resp_t r;
        r.op   = MEM_OP_READ;
        r.data = data;
        return r;
    endfunction

    function automatic mem_req_t randReq();
        mem_req_t r;
        r.op   = mem_op_t'($urandom_range(0, 1));
        r.addr = $urandom;
        r.data = $urandom;
        return r;
    endfunction

    function automatic mem_resp_t randResp();
        mem_resp_t r;
        r.op   = mem_op_t'($urandom_range(0, 1));
        r.data = $urandom;
        return r;
    endfunction

    // single comparison point: counts every check and reports any mismatch
    task automatic checkOutput(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(
        input logic iv, input mem_req_t im, input logic dv, input mem_req_t dm,
        input logic mrr, input logic rv, input mem_resp_t rm, input logic irr, input logic drr
    );
        imem_req_val  = iv;
        imem_req_msg  = im;
        dmem_req_val  = dv;
        dmem_req_msg  = dm;
        mem_req_rdy   = mrr;
        mem_resp_val  = rv;
        mem_resp_msg  = rm;
        imem_resp_rdy = irr;
        dmem_resp_rdy = drr;
    endtask

    task automatic resetModel();
        q.delete();
        last_id = 1;
        err     = 1'b0;
    endtask

    // compare the round-robin instance against the model for the current inputs
    task automatic checkAll();
        bit full, ci, cd, has, e_rv, e_ir, e_dr, e_mrr, e_iv, e_dv;
        int head;
        full = (q.size() == DEPTH);
        ci   = imem_req_val && !full;
        cd   = dmem_req_val && !full;
        if (ci && cd) e_win = (last_id == 0) ? 1 : 0;
        else          e_win = cd ? 1 : 0;
        e_rv = ci || cd;
        e_ir = e_rv && (e_win == 0) && mem_req_rdy;
        e_dr = e_rv && (e_win == 1) && mem_req_rdy;
        has  = (q.size() > 0);
        head = has ? q[0] : 0;
        e_iv  = has && mem_resp_val && (head == 0);
        e_dv  = has && mem_resp_val && (head == 1);
        e_mrr = has && ((head == 0) ? imem_resp_rdy : dmem_resp_rdy);
        e_req_fire  = e_rv && mem_req_rdy;
        e_resp_fire = e_mrr && mem_resp_val;
        e_spur      = mem_resp_val && !has;

        checkOutput("in_flight", in_flight, q.size());
        checkOutput("resp_err", resp_err, err);
        checkOutput("mem_req_val", mem_req_val, e_rv);
        checkOutput("imem_req_rdy", imem_req_rdy, e_ir);
        checkOutput("dmem_req_rdy", dmem_req_rdy, e_dr);
        if (e_rv)
            checkOutput("mem_req_msg", mem_req_msg, (e_win == 1) ? dmem_req_msg : imem_req_msg);
        checkOutput("imem_resp_val", imem_resp_val, e_iv);
        checkOutput("dmem_resp_val", dmem_resp_val, e_dv);
        checkOutput("mem_resp_rdy", mem_resp_rdy, e_mrr);
        checkOutput("imem_resp_msg", imem_resp_msg, mem_resp_msg);
        checkOutput("dmem_resp_msg", dmem_resp_msg, mem_resp_msg);
    endtask

    // check, take the clock edge, advance the model, return at the next negedge
    task automatic cycle();
        checkAll();
        @(posedge clk);
        if (e_resp_fire) void'(q.pop_front());
        if (e_req_fire) begin
            q.push_back(e_win);
            last_id = e_win;
        end
        if (e_spur) err = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        // reset with every input driven high
        rst = 1'b1;
        applyStimulus(1, mkReq(32'h40), 1, mkReq(32'h80), 1, 1, mkResp(32'h5), 1, 1);
        #1 rst = 1'b0;
        resetModel();
        #2;
        checkOutput("rst_imem_req_rdy", imem_req_rdy, 0);
        checkOutput("rst_dmem_req_rdy", dmem_req_rdy, 0);
        checkOutput("rst_mem_req_val", mem_req_val, 0);
        checkOutput("rst_mem_resp_rdy", mem_resp_rdy, 0);
        checkOutput("rst_imem_resp_val", imem_resp_val, 0);
        checkOutput("rst_dmem_resp_val", dmem_resp_val, 0);
        checkOutput("rst_in_flight", in_flight, 0);
        checkOutput("rst_resp_err", resp_err, 0);
        checkOutput("rst_f_mem_req_val", mem_req_val_f, 0);

        // round-robin tie: imem first, then dmem, responses routed in order
        @(negedge clk);
        applyStimulus(1, mkReq(32'h200), 1, mkReq(32'h1000), 1, 0, mkResp(0), 0, 0);
        rst = 1'b1;
        #1;
        checkOutput("rr1_imem_rdy", imem_req_rdy, 1);
        checkOutput("rr1_addr", mem_req_msg.addr, 32'h200);
        cycle();
        #1;
        checkOutput("rr2_dmem_rdy", dmem_req_rdy, 1);
        checkOutput("rr2_addr", mem_req_msg.addr, 32'h1000);
        cycle();
        applyStimulus(0, mkReq(0), 0, mkReq(0), 1, 1, mkResp(32'hA), 1, 1);
        #1;
        checkOutput("rr_resp_a_imem", imem_resp_val, 1);
        checkOutput("rr_resp_a_data", imem_resp_msg.data, 32'hA);
        cycle();
        applyStimulus(0, mkReq(0), 0, mkReq(0), 1, 1, mkResp(32'hB), 1, 1);
        #1;
        checkOutput("rr_resp_b_dmem", dmem_resp_val, 1);
        checkOutput("rr_resp_b_data", dmem_resp_msg.data, 32'hB);
        cycle();

        // fill the route FIFO with imem reads, then free one slot
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, mkReq(32'h300 + i), 0, mkReq(0), 1, 0, mkResp(0), 1, 1);
            #1;
            cycle();
        end
        applyStimulus(1, mkReq(32'h304), 0, mkReq(0), 1, 0, mkResp(0), 1, 1);
        #1;
        checkOutput("full_in_flight", in_flight, 4);
        checkOutput("full_imem_rdy", imem_req_rdy, 0);
        checkOutput("full_mem_req_val", mem_req_val, 0);
        cycle();
        applyStimulus(1, mkReq(32'h304), 0, mkReq(0), 1, 1, mkResp(32'h11), 1, 1);
        #1;
        checkOutput("full_pop_rdy", mem_resp_rdy, 1);
        checkOutput("full_pop_no_push", imem_req_rdy, 0);
        cycle();
        applyStimulus(1, mkReq(32'h304), 0, mkReq(0), 1, 0, mkResp(0), 1, 1);
        #1;
        checkOutput("full_5th_accept", imem_req_rdy, 1);
        cycle();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, mkReq(0), 0, mkReq(0), 1, 1, mkResp(32'h20 + i), 1, 1);
            #1;
            cycle();
        end

        // response backpressure from a dmem head
        applyStimulus(0, mkReq(0), 1, mkReq(32'h2000), 1, 0, mkResp(0), 1, 1);
        #1;
        cycle();
        applyStimulus(0, mkReq(0), 0, mkReq(0), 1, 1, mkResp(32'h33), 1, 0);
        #1;
        checkOutput("bp_mem_resp_rdy", mem_resp_rdy, 0);
        checkOutput("bp_imem_resp_val", imem_resp_val, 0);
        checkOutput("bp_dmem_resp_val", dmem_resp_val, 1);
        cycle();
        #1;
        checkOutput("bp_in_flight", in_flight, 1);
        applyStimulus(0, mkReq(0), 0, mkReq(0), 1, 1, mkResp(32'h33), 1, 1);
        #1;
        cycle();

        // spurious response with nothing outstanding
        applyStimulus(0, mkReq(0), 0, mkReq(0), 1, 1, mkResp(32'h44), 1, 1);
        #1;
        checkOutput("spur_mem_resp_rdy", mem_resp_rdy, 0);
        checkOutput("spur_imem_val", imem_resp_val, 0);
        checkOutput("spur_dmem_val", dmem_resp_val, 0);
        checkOutput("spur_err_before", resp_err, 0);
        cycle();
        applyStimulus(0, mkReq(0), 0, mkReq(0), 1, 0, mkResp(0), 1, 1);
        #1;
        checkOutput("spur_err_set", resp_err, 1);
        cycle();
        #1;
        checkOutput("spur_err_held", resp_err, 1);
        cycle();

        // random traffic against the model, after a fresh reset
        rst = 1'b0;
        #1 rst = 1'b1;
        resetModel();
        for (int n = 0; n < 400; n++) begin
            applyStimulus($urandom_range(0, 9) < 6, randReq(),
                          $urandom_range(0, 9) < 6, randReq(),
                          $urandom_range(0, 9) < 7,
                          (q.size() > 0) ? ($urandom_range(0, 9) < 5) : ($urandom_range(0, 99) < 2),
                          randResp(),
                          $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7);
            #1;
            cycle();
        end

        // fixed-priority instance: dmem wins every tie
        rst = 1'b0;
        #1 rst = 1'b1;
        resetModel();
        applyStimulus(1, mkReq(32'h500), 1, mkReq(32'h600), 1, 0, mkResp(0), 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("fixed_dmem_rdy", dmem_req_rdy_f, 1);
            checkOutput("fixed_imem_rdy", imem_req_rdy_f, 0);
            checkOutput("fixed_addr", mem_req_msg_f.addr, 32'h600);
            cycle();
        end
        applyStimulus(0, mkReq(0), 0, mkReq(0), 1, 1, mkResp(32'h55), 0, 1);
        #1;
        checkOutput("fixed_pop_rdy", mem_resp_rdy_f, 1);
        cycle();
        #1;
        checkOutput("fixed_in_flight_2", in_flight_f, 2);
        rst = 1'b0;
        #1;
        checkOutput("midrst_in_flight_f", in_flight_f, 0);
        checkOutput("midrst_in_flight", in_flight, 0);
        rst = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
